// File: rtl/tmds_pkg.sv
// Shared TMDS constants: the four control tokens, the receiver alignment
// states and the bit-offset width. Also used by the tmds_encoder benches.
package tmds_pkg;

   localparam logic [9:0] TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] TOKEN_11 = 10'b1010101011;

   localparam int OFFSET_W = 4;

   typedef enum logic {
      SEARCH,
      LOCKED
   } rx_state_t;

endpackage

// File: rtl/tmds_rx_decoder_if.sv
// Per-channel TMDS receive bundle: the raw deserialized word going in and the
// decoded pixel, control and alignment status coming out.
interface tmds_rx_decoder_if;
   import tmds_pkg::*;

   logic [9:0]          tmds_in;
   logic [7:0]          data_out;
   logic [1:0]          control_out;
   logic                de_out;
   logic                valid_out;
   logic                locked_out;
   logic [OFFSET_W-1:0] offset_out;

   modport master (
      output tmds_in,
      input  data_out, control_out, de_out, valid_out, locked_out, offset_out
   );

   modport slave (
      input  tmds_in,
      output data_out, control_out, de_out, valid_out, locked_out, offset_out
   );

endinterface

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into pixel data,
// control bits and a flag telling whether the symbol is a control token.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] symbol,
   output logic [7:0] data,
   output logic [1:0] control,
   output logic       is_token
);

   logic [7:0] q;

   // Bit 9 undoes the transmitter's DC-balance inversion; bit 8 selects XOR or XNOR chaining.
   always_comb begin
      q       = symbol[9] ? ~symbol[7:0] : symbol[7:0];
      data    = '0;
      data[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         data[i] = symbol[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
   end

   always_comb begin
      control  = 2'b00;
      is_token = 1'b1;
      case (symbol)
         TOKEN_00: control = 2'b00;
         TOKEN_01: control = 2'b01;
         TOKEN_10: control = 2'b10;
         TOKEN_11: control = 2'b11;
         default:  is_token = 1'b0;
      endcase
   end

endmodule

// File: rtl/tmds_rx_decoder.sv
// TMDS channel receiver: slides a 10-bit window over two consecutive raw words
// until control tokens line up, then decodes pixel data and control symbols.
module tmds_rx_decoder
   import tmds_pkg::*;
#(
   parameter int LOCK_COUNT    = 8,
   parameter int SEARCH_CYCLES = 4096,
   parameter int LOSS_CYCLES   = 4096
) (
   input  logic         clk_in,
   input  logic         rst_in,
   tmds_rx_decoder_if.slave rx
);

   localparam int TOK_W  = $clog2(LOCK_COUNT) + 1;
   localparam int CYC_W  = $clog2(SEARCH_CYCLES) + 1;
   localparam int LOSS_W = $clog2(LOSS_CYCLES) + 1;

   rx_state_t           state;
   logic [OFFSET_W-1:0] offset;
   logic [TOK_W-1:0]    tok_cnt;
   logic [CYC_W-1:0]    cyc_cnt;
   logic [LOSS_W-1:0]   loss_cnt;

   logic [9:0]  word_q;
   logic [9:0]  word_qq;
   logic [19:0] window;
   logic [4:0]  sel;
   logic [9:0]  aligned;

   logic [7:0]  sym_data;
   logic [1:0]  sym_ctl;
   logic        is_token;

   logic [7:0]  data_r;
   logic [1:0]  ctl_r;
   logic        de_r;
   logic        valid_r;

   // word_qq holds the older word, so low window bits arrive first on the wire.
   assign window  = {word_q, word_qq};
   assign sel     = {1'b0, offset};
   assign aligned = window[sel +: 10];

   tmds_symbol_decode u_decode (
      .symbol   (aligned),
      .data     (sym_data),
      .control  (sym_ctl),
      .is_token (is_token)
   );

   // Alignment FSM: hunt one offset at a time, lock on a run of tokens, drop on token starvation.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= SEARCH;
         offset   <= '0;
         tok_cnt  <= '0;
         cyc_cnt  <= '0;
         loss_cnt <= '0;
      end else begin
         case (state)
            SEARCH: begin
               if (cyc_cnt == CYC_W'(SEARCH_CYCLES - 1)) begin
                  offset  <= (offset == OFFSET_W'(9)) ? '0 : offset + OFFSET_W'(1);
                  tok_cnt <= '0;
                  cyc_cnt <= '0;
               end else if (is_token && (tok_cnt == TOK_W'(LOCK_COUNT - 1))) begin
                  state    <= LOCKED;
                  tok_cnt  <= '0;
                  cyc_cnt  <= '0;
                  loss_cnt <= '0;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
                  tok_cnt <= is_token ? tok_cnt + TOK_W'(1) : '0;
               end
            end
            LOCKED: begin
               if (is_token) begin
                  loss_cnt <= '0;
               end else if (loss_cnt == LOSS_W'(LOSS_CYCLES - 1)) begin
                  state    <= SEARCH;
                  loss_cnt <= '0;
                  tok_cnt  <= '0;
                  cyc_cnt  <= '0;
               end else begin
                  loss_cnt <= loss_cnt + LOSS_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         word_q  <= '0;
         word_qq <= '0;
         data_r  <= '0;
         ctl_r   <= '0;
         de_r    <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         word_q  <= rx.tmds_in;
         word_qq <= word_q;
         data_r  <= is_token ? 8'h00 : sym_data;
         de_r    <= ~is_token;
         valid_r <= (state == LOCKED);
         if (is_token) begin
            ctl_r <= sym_ctl;
         end
      end
   end

   assign rx.data_out    = data_r;
   assign rx.control_out = ctl_r;
   assign rx.de_out      = de_r;
   assign rx.valid_out   = valid_r;
   assign rx.locked_out  = (state == LOCKED);
   assign rx.offset_out  = offset;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: directed alignment/loss/reset scenarios plus
// randomized pixel traffic scored against a bit-level decode reference.
module tb_tmds_rx_decoder;

   localparam int SEARCH_CYCLES = 4096;
   localparam int LOSS_CYCLES   = 4096;
   localparam int LOCK_COUNT    = 8;

   localparam logic [9:0] TOKENS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   tmds_rx_decoder_if rx();

   tmds_rx_decoder #(
      .LOCK_COUNT    (LOCK_COUNT),
      .SEARCH_CYCLES (SEARCH_CYCLES),
      .LOSS_CYCLES   (LOSS_CYCLES)
   ) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .rx     (rx)
   );

   int         checks = 0;
   int         errors = 0;
   logic [9:0] sent [$];
   logic [1:0] lastCtl;
   bit         scoreOn;
   logic [9:0] rw;
   logic [9:0] rotTok;

   function automatic int tokenIndex(input logic [9:0] w);
      for (int i = 0; i < 4; i++) begin
         if (w == TOKENS[i]) return i;
      end
      return -1;
   endfunction

   // Reference decode: XOR each bit with its lower neighbour, flip bits 1..7 for XNOR mode.
   function automatic logic [7:0] refDecode(input logic [9:0] w);
      logic [7:0] q;
      logic [7:0] d;
      q = w[9] ? ~w[7:0] : w[7:0];
      d = q ^ (q << 1);
      if (!w[8]) d = d ^ 8'hFE;
      return d;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_data"},    16'(rx.data_out),    16'h0);
      checkOutput({tag, "_control"}, 16'(rx.control_out), 16'h0);
      checkOutput({tag, "_de"},      16'(rx.de_out),      16'h0);
      checkOutput({tag, "_valid"},   16'(rx.valid_out),   16'h0);
      checkOutput({tag, "_locked"},  16'(rx.locked_out),  16'h0);
      checkOutput({tag, "_offset"},  16'(rx.offset_out),  16'h0);
   endtask

   // Drive one word, let it be sampled, then score the word two edges older (offset 0 pipeline).
   task automatic applyStimulus(input logic [9:0] w);
      logic [9:0] old;
      int         idx;
      rx.tmds_in = w;
      @(posedge clk);
      #1;
      sent.push_back(w);
      if (sent.size() >= 3) begin
         old = sent[sent.size() - 3];
         idx = tokenIndex(old);
         if (idx >= 0) lastCtl = 2'(idx);
         if (scoreOn) begin
            checkOutput("sb_valid",   16'(rx.valid_out),   16'h1);
            checkOutput("sb_de",      16'(rx.de_out),      (idx < 0) ? 16'h1 : 16'h0);
            checkOutput("sb_control", 16'(rx.control_out), 16'(lastCtl));
            if (idx < 0) checkOutput("sb_data", 16'(rx.data_out), 16'(refDecode(old)));
         end
      end
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      repeat (3) begin
         applyStimulus(10'($urandom_range(0, 1023)));
         checkAllZero("reset");
      end
      rst_n = 1'b1;
      sent.delete();
      lastCtl = 2'b00;
   endtask

   initial begin
      rst_n      = 1'b0;
      rx.tmds_in = '0;
      scoreOn    = 1'b0;
      lastCtl    = 2'b00;

      doReset();
      applyStimulus(10'h000);
      checkOutput("post_reset_locked", 16'(rx.locked_out), 16'h0);

      // Seven tokens then a break must not lock; the following run of eight must.
      doReset();
      repeat (7) applyStimulus(TOKENS[0]);
      applyStimulus(10'h1FF);
      repeat (8) applyStimulus(TOKENS[0]);
      applyStimulus(10'h1FF);
      checkOutput("lock0_early", 16'(rx.locked_out), 16'h0);
      applyStimulus(10'h200);
      checkOutput("lock0_locked",  16'(rx.locked_out),  16'h1);
      checkOutput("lock0_offset",  16'(rx.offset_out),  16'h0);
      checkOutput("lock0_control", 16'(rx.control_out), 16'h0);
      checkOutput("lock0_de",      16'(rx.de_out),      16'h0);
      checkOutput("lock0_valid",   16'(rx.valid_out),   16'h0);
      applyStimulus(10'h1FF);
      checkOutput("dec_1ff_data",  16'(rx.data_out),    16'h01);
      checkOutput("dec_1ff_de",    16'(rx.de_out),      16'h1);
      checkOutput("dec_1ff_valid", 16'(rx.valid_out),   16'h1);
      applyStimulus(10'h1FF);
      checkOutput("dec_200_data",  16'(rx.data_out),    16'hFF);
      checkOutput("dec_200_ctl",   16'(rx.control_out), 16'h0);

      // Random pixel traffic with occasional tokens to keep lock alive.
      scoreOn = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            rw = TOKENS[$urandom_range(0, 3)];
         end else begin
            do rw = 10'($urandom_range(0, 1023)); while (tokenIndex(rw) >= 0);
         end
         applyStimulus(rw);
      end
      scoreOn = 1'b0;

      // Asynchronous reset while locked clears outputs without a clock edge.
      applyStimulus(TOKENS[3]);
      repeat (3) applyStimulus(10'h1FF);
      checkOutput("pre_async_locked",  16'(rx.locked_out),  16'h1);
      checkOutput("pre_async_control", 16'(rx.control_out), 16'h3);
      rst_n = 1'b0;
      #2;
      checkAllZero("async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sent.delete();
      lastCtl = 2'b00;
      repeat (8) applyStimulus(TOKENS[2]);
      applyStimulus(10'h1FF);
      checkOutput("relock_early",   16'(rx.locked_out),  16'h0);
      applyStimulus(10'h1FF);
      checkOutput("relock_locked",  16'(rx.locked_out),  16'h1);
      checkOutput("relock_control", 16'(rx.control_out), 16'h2);

      // Token stream shifted by 3 bits: offset walks 0..3 then locks.
      doReset();
      rotTok = {TOKENS[2][6:0], TOKENS[2][9:7]};
      for (int n = 0; n <= 3 * SEARCH_CYCLES - 1 + LOCK_COUNT; n++) begin
         applyStimulus(rotTok);
         if (n == SEARCH_CYCLES - 2)     checkOutput("slip_before_1", 16'(rx.offset_out), 16'h0);
         if (n == SEARCH_CYCLES - 1)     checkOutput("slip_to_1",     16'(rx.offset_out), 16'h1);
         if (n == 2 * SEARCH_CYCLES - 1) checkOutput("slip_to_2",     16'(rx.offset_out), 16'h2);
         if (n == 3 * SEARCH_CYCLES - 1) checkOutput("slip_to_3",     16'(rx.offset_out), 16'h3);
         if (n == 3 * SEARCH_CYCLES - 2 + LOCK_COUNT)
            checkOutput("lock3_early", 16'(rx.locked_out), 16'h0);
      end
      checkOutput("lock3_locked",  16'(rx.locked_out),  16'h1);
      checkOutput("lock3_offset",  16'(rx.offset_out),  16'h3);
      checkOutput("lock3_control", 16'(rx.control_out), 16'h2);

      // Starve tokens: lock drops after LOSS_CYCLES non-token words, offset retained.
      for (int k = 1; k <= LOSS_CYCLES + 2; k++) begin
         applyStimulus(10'h000);
         if (k == LOSS_CYCLES)     checkOutput("loss_hold",   16'(rx.locked_out), 16'h1);
         if (k == LOSS_CYCLES + 1) checkOutput("loss_drop",   16'(rx.locked_out), 16'h0);
         if (k == LOSS_CYCLES + 1) checkOutput("loss_offset", 16'(rx.offset_out), 16'h3);
         if (k == LOSS_CYCLES + 2) checkOutput("loss_valid",  16'(rx.valid_out),  16'h0);
      end
      for (int j = 1; j <= 10; j++) begin
         applyStimulus(rotTok);
         if (j == 9) checkOutput("relock3_early", 16'(rx.locked_out), 16'h0);
      end
      checkOutput("relock3_locked", 16'(rx.locked_out), 16'h1);
      checkOutput("relock3_offset", 16'(rx.offset_out), 16'h3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
